// File: rtl/instr_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared constants, fetch-entry record and address-limit helper
//             for the instruction fetch sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int unsigned WORD_BYTES        = 4;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam int unsigned MEM_WORDS_DEFAULT = 50;

   // One buffered fetch: the address it came from and the word returned.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // First byte address past the end of an instruction memory of mem_words.
   function automatic logic [31:0] byte_limit(input int unsigned mem_words);
      return 32'(mem_words * WORD_BYTES);
   endfunction

   localparam logic [31:0] BYTE_LIMIT_DEFAULT = byte_limit(MEM_WORDS_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/instr_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_sequencer_if
//  Brief    : Memory, decode handshake, redirect and status signals of the
//             fetch sequencer. master = fetch side, slave = environment side.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_sequencer_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        pc_oob;
   logic        fault;

   modport master (
      output imem_addr,
      input  imem_instr,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      input  redirect,
      input  redirect_pc,
      output pc_oob,
      output fault
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      output redirect,
      output redirect_pc,
      input  pc_oob,
      input  fault
   );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_sequencer_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Two-entry FIFO of fetch entries. Push and pop together are
//             legal when full; flush overrides both. The head keeps its last
//             contents after the queue drains.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
   import fetch_pkg::*;
(
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         push,
   input  wire logic         pop,
   input  wire logic         flush,
   input  wire fetch_entry_t push_entry,
   output logic              full,
   output logic              empty,
   output fetch_entry_t      head
);

   fetch_entry_t r_entry0;
   fetch_entry_t r_entry1;
   logic [1:0]   r_count;
   logic         w_do_pop;
   logic         w_do_push;

   // Qualify requests against occupancy; a pop frees room for a push.
   always_comb begin
      w_do_pop  = pop & (r_count != 2'd0);
      w_do_push = push & ((r_count != 2'd2) | w_do_pop);
   end

   // Shift-style storage: entry0 is always the head.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count  <= 2'd0;
         r_entry0 <= '0;
         r_entry1 <= '0;
      end else if (flush) begin
         r_count <= 2'd0;
      end else begin
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 2'd1;
         else if (!w_do_push && w_do_pop)
            r_count <= r_count - 2'd1;

         if (w_do_pop && r_count == 2'd2)
            r_entry0 <= r_entry1;

         if (w_do_push) begin
            if (r_count == 2'd0 || (r_count == 2'd1 && w_do_pop))
               r_entry0 <= push_entry;
            else
               r_entry1 <= push_entry;
         end
      end
   end

   assign full  = (r_count == 2'd2);
   assign empty = (r_count == 2'd0);
   assign head  = r_entry0;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_sequencer
//  Brief    : Fetch front end: owns the PC, addresses instruction memory,
//             buffers words toward decode, handles redirects and stops on an
//             out-of-range PC or a misaligned redirect target.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
)
(
   input  wire logic               clk,
   input  wire logic               reset,
   instr_fetch_sequencer_if.master bus
);

   localparam logic [31:0] PC_LIMIT = byte_limit(MEM_WORDS);

   logic [31:0]  r_pc;
   logic         r_fault;
   logic         w_pc_oob;
   logic         w_take_redirect;
   logic         w_bad_target;
   logic         w_pop;
   logic         w_push;
   logic         w_q_full;
   logic         w_q_empty;
   fetch_entry_t w_head;
   fetch_entry_t w_new_entry;

   // Handshake, redirect qualification and push enable.
   always_comb begin
      w_pc_oob        = (r_pc >= PC_LIMIT);
      w_take_redirect = bus.redirect & ~r_fault;
      w_bad_target    = w_take_redirect & (bus.redirect_pc[1:0] != 2'b00);
      w_pop           = ~w_q_empty & bus.out_ready;
      w_push          = ~bus.redirect & ~r_fault & ~w_pc_oob & (~w_q_full | w_pop);
      w_new_entry.pc    = r_pc;
      w_new_entry.instr = bus.imem_instr;
   end

   // PC and sticky fault: a taken redirect wins, otherwise advance on push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
      end else if (w_take_redirect) begin
         if (w_bad_target)
            r_fault <= 1'b1;
         else
            r_pc <= bus.redirect_pc;
      end else if (w_push) begin
         r_pc <= r_pc + 32'(WORD_BYTES);
      end
   end

   fetch_queue u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .pop        (w_pop),
      .flush      (w_take_redirect),
      .push_entry (w_new_entry),
      .full       (w_q_full),
      .empty      (w_q_empty),
      .head       (w_head)
   );

   assign bus.imem_addr = r_pc;
   assign bus.out_valid = ~w_q_empty;
   assign bus.out_instr = w_head.instr;
   assign bus.out_pc    = w_head.pc;
   assign bus.pc_oob    = w_pc_oob;
   assign bus.fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_sequencer
//  Brief    : Self-checking bench: directed scenarios plus randomized traffic
//             compared every cycle against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_sequencer;
   import fetch_pkg::*;

   localparam int unsigned MEM_WORDS = 50;
   localparam logic [31:0] LIMIT     = 32'd200;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   instr_fetch_sequencer_if bus();

   instr_fetch_sequencer #(
      .RESET_PC  (32'h0000_0000),
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory image; out-of-range reads return a recognisable junk word.
   logic [31:0] mem [MEM_WORDS];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < LIMIT)
         return mem[a[7:2]];
      return 32'hBAD0_0000 ^ a;
   endfunction

   assign bus.imem_instr = mem_word(bus.imem_addr);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of {pc,instr}, fetch pointer and sticky fault.
   fetch_entry_t m_q[$];
   logic [31:0]  m_pc    = 32'h0;
   bit           m_fault = 1'b0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_q.delete();
         m_pc    = 32'h0;
         m_fault = 1'b0;
      end else if (bus.redirect && !m_fault) begin
         m_q.delete();
         if (bus.redirect_pc % 4 != 0)
            m_fault = 1'b1;
         else
            m_pc = bus.redirect_pc;
      end else begin
         if (m_q.size() > 0 && bus.out_ready)
            void'(m_q.pop_front());
         if (!bus.redirect && !m_fault && m_pc < LIMIT && m_q.size() < 2) begin
            m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         check("m_imem_addr", bus.imem_addr, m_pc);
         check("m_out_valid", {31'b0, bus.out_valid}, {31'b0, m_q.size() > 0});
         if (m_q.size() > 0) begin
            check("m_out_pc", bus.out_pc, m_q[0].pc);
            check("m_out_instr", bus.out_instr, m_q[0].instr);
         end
         check("m_pc_oob", {31'b0, bus.pc_oob}, {31'b0, m_pc >= LIMIT});
         check("m_fault", {31'b0, bus.fault}, {31'b0, m_fault});
      end
   end

   task automatic next_drive();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      next_drive();
      reset = 1'b1;
      next_drive();
      reset = 1'b0;
   endtask

   initial begin
      int r;
      for (int i = 0; i < int'(MEM_WORDS); i++)
         mem[i] = $urandom;
      bus.out_ready   = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;

      // Reset state
      @(negedge clk);
      check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_instr", bus.out_instr, 32'h0);
      check("rst_pc", bus.out_pc, 32'h0);
      check("rst_fault", {31'b0, bus.fault}, 32'd0);
      check("rst_oob", {31'b0, bus.pc_oob}, 32'd0);

      // Streaming with out_ready held high
      next_drive();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t1_first_invalid", {31'b0, bus.out_valid}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t1_valid", {31'b0, bus.out_valid}, 32'd1);
         check("t1_pc", bus.out_pc, 32'(4 * k));
         check("t1_instr", bus.out_instr, mem[k]);
      end

      // Backpressure fills the queue, then drains in order
      bus.out_ready = 1'b0;
      apply_reset();
      repeat (5) @(negedge clk);
      check("t2_valid", {31'b0, bus.out_valid}, 32'd1);
      check("t2_addr_hold", bus.imem_addr, 32'h8);
      next_drive();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t2_drain_pc", bus.out_pc, 32'(4 * k));
      end

      // Redirect while full with out_ready high
      next_drive();
      bus.out_ready   = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h10;
      next_drive();
      bus.redirect = 1'b0;
      repeat (2) @(negedge clk);
      check("t3_full_head", bus.out_pc, 32'h10);
      next_drive();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h74;
      bus.out_ready   = 1'b1;
      next_drive();
      bus.redirect = 1'b0;
      @(negedge clk);
      check("t3_flushed", {31'b0, bus.out_valid}, 32'd0);
      check("t3_addr", bus.imem_addr, 32'h74);
      @(negedge clk);
      check("t3_target_pc", bus.out_pc, 32'h74);
      check("t3_target_instr", bus.out_instr, mem[29]);

      // Fetch up to the end of memory, then resume from 0
      next_drive();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hC4;
      next_drive();
      bus.redirect = 1'b0;
      @(negedge clk);
      check("t4_addr", bus.imem_addr, 32'hC4);
      @(negedge clk);
      check("t4_last_pc", bus.out_pc, 32'hC4);
      check("t4_last_instr", bus.out_instr, mem[49]);
      check("t4_oob", {31'b0, bus.pc_oob}, 32'd1);
      check("t4_addr_end", bus.imem_addr, 32'hC8);
      repeat (2) @(negedge clk);
      check("t4_drained", {31'b0, bus.out_valid}, 32'd0);
      next_drive();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0;
      next_drive();
      bus.redirect = 1'b0;
      @(negedge clk);
      check("t4_resume_oob", {31'b0, bus.pc_oob}, 32'd0);
      @(negedge clk);
      check("t4_resume_pc", bus.out_pc, 32'h0);

      // Misaligned redirect raises a sticky fault
      bus.out_ready = 1'b0;
      apply_reset();
      repeat (4) @(negedge clk);
      next_drive();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h22;
      next_drive();
      bus.redirect = 1'b0;
      @(negedge clk);
      check("t5_fault", {31'b0, bus.fault}, 32'd1);
      check("t5_empty", {31'b0, bus.out_valid}, 32'd0);
      check("t5_addr", bus.imem_addr, 32'h8);
      next_drive();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0;
      bus.out_ready   = 1'b1;
      next_drive();
      bus.redirect = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_fault_sticky", {31'b0, bus.fault}, 32'd1);
      check("t5_addr_frozen", bus.imem_addr, 32'h8);

      // Asynchronous reset with two entries queued and pc at 0x30
      bus.out_ready = 1'b0;
      apply_reset();
      next_drive();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h28;
      next_drive();
      bus.redirect = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_pre_addr", bus.imem_addr, 32'h30);
      check("t6_pre_head", bus.out_pc, 32'h28);
      #1 reset = 1'b1;
      #1;
      check("t6_async_valid", {31'b0, bus.out_valid}, 32'd0);
      check("t6_async_addr", bus.imem_addr, 32'h0);
      next_drive();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_restart_pc", bus.out_pc, 32'h0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         next_drive();
         bus.out_ready = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 99);
         bus.redirect = (r < 8);
         if ($urandom_range(0, 19) == 0)
            bus.redirect_pc = 32'($urandom_range(0, 255));
         else
            bus.redirect_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         reset = ($urandom_range(0, 99) == 0);
      end
      next_drive();
      reset = 1'b0;
      bus.redirect = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
